wb_sdrc_arb: RTL and testbench

WB_SDRC_ARB -- requirements
Module: wb_sdrc_arb

---
 rtl/wb_sdrc_arb_pkg.sv | 28 ++
 rtl/wb_rr_pick.sv | 33 +++
 rtl/wb_sdrc_arb.sv | 152 +++++++++++++++
 tb/tb_wb_sdrc_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sdrc_arb_pkg.sv
// Shared types and defaults for the Wishbone-to-SDRAM-controller arbiter.
package wb_sdrc_arb_pkg;

  localparam int unsigned DEF_NUM_M   = 4;
  localparam int unsigned DEF_AW      = 32;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_TMO_CYC = 255;

  // Bus ownership phases: nobody owns, a master owns, one dead cycle after release.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    REL  = 2'd2
  } arb_state_t;

  // Width of a master index; at least one bit so a single-master build still has a vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timeout counter width: wide enough to hold TMO_CYC, never narrower than 8 bits.
  function automatic int unsigned tmo_cnt_width(input int unsigned tmo);
    int unsigned w;
    w = $clog2(tmo + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: one-hot grant plus index of the winner.
module wb_rr_pick
  import wb_sdrc_arb_pkg::*;
#(
  parameter int unsigned NUM_M = DEF_NUM_M,
  parameter int unsigned IW    = idx_width(DEF_NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic [NUM_M-1:0] grant_c,
  output logic [IW-1:0]    grant_idx_c
);

  logic        found;
  int unsigned cand;

  // Search starts just after the previous owner and wraps, so the previous owner is tried last.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    cand        = 0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      cand = (32'(last_owner) + k) % NUM_M;
      if (!found && req[IW'(cand)]) begin
        found                = 1'b1;
        grant_c[IW'(cand)]   = 1'b1;
        grant_idx_c          = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_sdrc_arb.sv
// Round-robin Wishbone arbiter in front of a single SDRAM controller port.
// An owner keeps the bus for as long as it holds m_cyc_i (bursts, read-modify-write),
// a stalled slave is cut off after TMO_CYC strobe cycles with an error to the owner,
// and every hand-over passes through one dead cycle.
module wb_sdrc_arb
  import wb_sdrc_arb_pkg::*;
#(
  parameter int unsigned NUM_M   = DEF_NUM_M,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TMO_CYC = DEF_TMO_CYC
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_M-1:0]          m_cyc_i,
  input  logic [NUM_M-1:0]          m_stb_i,
  input  logic [NUM_M-1:0]          m_we_i,
  input  logic [NUM_M*AW-1:0]       m_adr_i,
  input  logic [NUM_M*DW-1:0]       m_dat_i,
  input  logic [NUM_M*(DW/8)-1:0]   m_sel_i,
  output logic [NUM_M-1:0]          m_ack_o,
  output logic [NUM_M-1:0]          m_err_o,
  output logic [DW-1:0]             m_dat_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [DW/8-1:0]           s_sel_o,
  input  logic                      s_ack_i,
  input  logic [DW-1:0]             s_dat_i,
  output logic [NUM_M-1:0]          grant_o,
  output logic                      busy_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = idx_width(NUM_M);
  localparam int unsigned CW = tmo_cnt_width(TMO_CYC);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    last_owner_q;
  logic [CW-1:0]    tmo_cnt_q;
  logic [NUM_M-1:0] pick_grant_c;
  logic [IW-1:0]    pick_idx_c;
  logic             owner_cyc_c;
  logic             tmo_hit_c;
  logic             release_c;

  wb_rr_pick #(
    .NUM_M (NUM_M),
    .IW    (IW)
  ) u_pick (
    .req         (m_cyc_i),
    .last_owner  (last_owner_q),
    .grant_c     (pick_grant_c),
    .grant_idx_c (pick_idx_c)
  );

  // Read data goes to every master; only the owner sees an ack for it.
  assign m_dat_o = s_dat_i;

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: arbitrate from IDLE, hold while the owner keeps cyc, one REL cycle on hand-over.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|m_cyc_i) state_d = OWN;
      OWN:     if (release_c) state_d = REL;
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: slave side muxed from the owner with no added latency, plus release/timeout decode.
  always_comb begin
    s_cyc_o     = 1'b0;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    s_adr_o     = '0;
    s_dat_o     = '0;
    s_sel_o     = '0;
    m_ack_o     = '0;
    owner_cyc_c = 1'b0;
    tmo_hit_c   = 1'b0;
    release_c   = 1'b0;
    if (state_q == OWN) begin
      s_cyc_o = 1'b1;
      for (int unsigned i = 0; i < NUM_M; i++) begin
        if (grant_o[i]) begin
          s_stb_o     = m_stb_i[i];
          s_we_o      = m_we_i[i];
          s_adr_o     = m_adr_i[i*AW +: AW];
          s_dat_o     = m_dat_i[i*DW +: DW];
          s_sel_o     = m_sel_i[i*SW +: SW];
          owner_cyc_c = m_cyc_i[i];
        end
      end
      m_ack_o   = grant_o & {NUM_M{s_ack_i}};
      // An ack on the last allowed stall cycle still completes the access.
      tmo_hit_c = s_stb_o & ~s_ack_i & (tmo_cnt_q == CW'(TMO_CYC - 1));
      release_c = tmo_hit_c | ~owner_cyc_c;
    end
  end

  // Grant, busy and owner bookkeeping; last_owner seeds the next round-robin search.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      grant_o      <= '0;
      busy_o       <= 1'b0;
      owner_q      <= '0;
      last_owner_q <= IW'(NUM_M - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|m_cyc_i) begin
            grant_o <= pick_grant_c;
            owner_q <= pick_idx_c;
            busy_o  <= 1'b1;
          end
        end
        OWN: begin
          if (release_c) begin
            grant_o      <= '0;
            busy_o       <= 1'b0;
            last_owner_q <= owner_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall counter and one-cycle error pulse to the owner on timeout.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt_q <= '0;
      m_err_o   <= '0;
    end else begin
      m_err_o <= tmo_hit_c ? grant_o : '0;
      if (!s_stb_o || s_ack_i || tmo_hit_c) tmo_cnt_q <= '0;
      else                                  tmo_cnt_q <= tmo_cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_wb_sdrc_arb.sv
// Bench for wb_sdrc_arb: directed scenarios plus random traffic against a cycle model.
module tb_wb_sdrc_arb;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 255;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_cyc = '0;
  logic [N-1:0]    m_stb = '0;
  logic [N-1:0]    m_we  = '0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*DW-1:0] m_dat = '0;
  logic [N*SW-1:0] m_sel = '0;
  logic            s_ack = 1'b0;
  logic [DW-1:0]   s_dat = '0;

  logic [N-1:0]    d_m_ack, d_m_err, d_grant;
  logic [DW-1:0]   d_m_dat;
  logic            d_s_cyc, d_s_stb, d_s_we, d_busy;
  logic [AW-1:0]   d_s_adr;
  logic [DW-1:0]   d_s_dat;
  logic [SW-1:0]   d_s_sel;

  wb_sdrc_arb #(.NUM_M(N), .AW(AW), .DW(DW), .TMO_CYC(TMO)) dut (
    .wb_clk_i (clk),     .wb_rst_i (rst),
    .m_cyc_i  (m_cyc),   .m_stb_i  (m_stb),   .m_we_i  (m_we),
    .m_adr_i  (m_adr),   .m_dat_i  (m_dat),   .m_sel_i (m_sel),
    .m_ack_o  (d_m_ack), .m_err_o  (d_m_err), .m_dat_o (d_m_dat),
    .s_cyc_o  (d_s_cyc), .s_stb_o  (d_s_stb), .s_we_o  (d_s_we),
    .s_adr_o  (d_s_adr), .s_dat_o  (d_s_dat), .s_sel_o (d_s_sel),
    .s_ack_i  (s_ack),   .s_dat_i  (s_dat),
    .grant_o  (d_grant), .busy_o   (d_busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: who owns the bus, whether we are in the dead cycle after a release,
  // who owned last, how many consecutive unacked strobe cycles, who gets an error this cycle.
  int mdl_own   = -1;
  int mdl_last  = N - 1;
  int mdl_stall = 0;
  int mdl_err   = -1;
  bit mdl_dead  = 1'b0;

  task automatic model_reset();
    mdl_own = -1; mdl_last = N - 1; mdl_stall = 0; mdl_err = -1; mdl_dead = 1'b0;
  endtask

  task automatic model_step();
    int nerr;
    nerr = -1;
    if (mdl_own >= 0) begin
      if (m_stb[mdl_own] && !s_ack) mdl_stall++;
      else                          mdl_stall = 0;
      if (mdl_stall == TMO || !m_cyc[mdl_own]) begin
        if (mdl_stall == TMO) nerr = mdl_own;
        mdl_last = mdl_own; mdl_own = -1; mdl_dead = 1'b1; mdl_stall = 0;
      end
    end else if (mdl_dead) begin
      mdl_dead = 1'b0;
    end else begin
      mdl_stall = 0;
      for (int k = 1; k <= N; k++) begin
        if (mdl_own < 0 && m_cyc[(mdl_last + k) % N]) mdl_own = (mdl_last + k) % N;
      end
    end
    mdl_err = nerr;
  endtask

  task automatic compare_outputs();
    logic [N-1:0]  e_grant, e_ack, e_err;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    e_grant = '0; e_ack = '0; e_err = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0;
    if (mdl_own >= 0) begin
      e_grant = N'(1) << mdl_own;
      e_cyc   = 1'b1;
      e_stb   = m_stb[mdl_own];
      e_we    = m_we[mdl_own];
      e_adr   = m_adr[mdl_own*AW +: AW];
      e_dat   = m_dat[mdl_own*DW +: DW];
      e_sel   = m_sel[mdl_own*SW +: SW];
      e_ack   = s_ack ? e_grant : '0;
    end
    if (mdl_err >= 0) e_err = N'(1) << mdl_err;
    chk("mdl_grant", 64'(d_grant), 64'(e_grant));
    chk("mdl_busy",  64'(d_busy),  64'(mdl_own >= 0));
    chk("mdl_s_cyc", 64'(d_s_cyc), 64'(e_cyc));
    chk("mdl_s_stb", 64'(d_s_stb), 64'(e_stb));
    chk("mdl_s_we",  64'(d_s_we),  64'(e_we));
    chk("mdl_s_adr", 64'(d_s_adr), 64'(e_adr));
    chk("mdl_s_dat", 64'(d_s_dat), 64'(e_dat));
    chk("mdl_s_sel", 64'(d_s_sel), 64'(e_sel));
    chk("mdl_m_ack", 64'(d_m_ack), 64'(e_ack));
    chk("mdl_m_err", 64'(d_m_err), 64'(e_err));
    chk("mdl_m_dat", 64'(d_m_dat), 64'(s_dat));
  endtask

  // Compare on the falling edge, advance the model on the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      if (cmp_en) compare_outputs();
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
    repeat (4) tick();
  endtask

  int n, g, w, gap;
  int hold [N];

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_grant", 64'(d_grant), 64'd0);
    chk("rst_busy",  64'(d_busy),  64'd0);
    chk("rst_s_cyc", 64'(d_s_cyc), 64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Single write from master 0
    m_cyc = 4'b0001; m_stb = 4'b0001; m_we = 4'b0001;
    m_adr[0 +: AW] = 32'h0000_0100; m_dat[0 +: DW] = 32'hCAFE_0001; m_sel[0 +: SW] = 4'hF;
    #1 chk("w0_pre_grant", 64'(d_grant), 64'd0);
    tick();
    chk("w0_grant", 64'(d_grant), 64'b0001);
    chk("w0_busy",  64'(d_busy),  64'd1);
    chk("w0_s_adr", 64'(d_s_adr), 64'h100);
    chk("w0_s_dat", 64'(d_s_dat), 64'hCAFE_0001);
    chk("w0_s_we",  64'(d_s_we),  64'd1);
    chk("w0_mdl_own", 64'(mdl_own), 64'd0);
    s_ack = 1'b1;
    #1 chk("w0_ack_on", 64'(d_m_ack), 64'b0001);
    s_ack = 1'b0;
    #1 chk("w0_ack_off", 64'(d_m_ack), 64'd0);
    quiesce();

    // Fresh reset, then all four request: order 0,1,2,3,0 with REL+IDLE between owners
    rst = 1'b1; tick(); rst = 1'b0; tick();
    m_cyc = 4'hF; m_stb = 4'hF; m_we = '0;
    for (int k = 0; k < 5; k++) begin
      w = k % N;
      gap = 0;
      while (d_grant == '0 && gap < 10) begin gap++; tick(); end
      chk("rr_order", 64'(d_grant), 64'(N'(1) << w));
      chk("rr_mdl_own", 64'(mdl_own), 64'(w));
      if (k > 0) chk("rr_gap", 64'(gap), 64'd2);
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      m_cyc = m_cyc & ~(N'(1) << w); m_stb = m_stb & ~(N'(1) << w);
      tick();
      m_cyc = m_cyc | (N'(1) << w); m_stb = m_stb | (N'(1) << w);
    end
    quiesce();

    // Master 2 burst with strobe gaps while master 1 waits
    m_cyc = 4'b0100; m_stb = '0;
    tick();
    chk("bu_grant", 64'(d_grant), 64'b0100);
    m_cyc = 4'b0110;
    for (int c = 0; c < 8; c++) begin
      m_stb = (c % 2 == 0) ? 4'b0110 : 4'b0010;
      s_ack = (c % 2 == 0);
      #1;
      chk("bu_hold", 64'(d_grant), 64'b0100);
      chk("bu_m1_noack", 64'(d_m_ack[1]), 64'd0);
      if (c % 2 == 0) chk("bu_m2_ack", 64'(d_m_ack), 64'b0100);
      tick();
    end
    s_ack = 1'b0; m_stb = 4'b0010; m_cyc = 4'b0010;
    tick(); chk("bu_rel", 64'(d_grant), 64'd0);
    tick(); chk("bu_idle", 64'(d_grant), 64'd0);
    tick(); chk("bu_next", 64'(d_grant), 64'b0010);
    quiesce();

    // Random traffic, model checked every cycle
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_cyc[i]) begin
          if ($urandom_range(3) == 0) begin m_cyc[i] = 1'b1; hold[i] = $urandom_range(8, 1); end
        end else if (hold[i] == 0) m_cyc[i] = 1'b0;
        else hold[i]--;
        m_stb[i] = m_cyc[i] & ($urandom_range(3) != 0);
        m_we[i]  = 1'($urandom_range(1));
      end
      m_adr = {$urandom, $urandom, $urandom, $urandom};
      m_dat = {$urandom, $urandom, $urandom, $urandom};
      m_sel = 16'($urandom);
      s_ack = 1'($urandom_range(1));
      s_dat = $urandom;
      tick();
    end
    quiesce();

    // Slave never acks: error pulse after TMO_CYC strobe cycles, bus released
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
    n = 0; g = 0;
    while (d_m_err == '0 && g < 400) begin if (d_s_stb) n++; g++; tick(); end
    chk("tmo_cycles", 64'(n), 64'd255);
    chk("tmo_err", 64'(d_m_err), 64'b0010);
    chk("tmo_mdl_err", 64'(mdl_err), 64'd1);
    chk("tmo_grant", 64'(d_grant), 64'd0);
    chk("tmo_s_cyc", 64'(d_s_cyc), 64'd0);
    tick();
    chk("tmo_pulse", 64'(d_m_err), 64'd0);
    quiesce();

    // Ack on the last allowed stall cycle wins over the timeout
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
    n = 0; g = 0;
    while (g < 300) begin
      if (d_s_stb) n++;
      if (n == 255) break;
      g++; tick();
    end
    chk("a255_cycles", 64'(n), 64'd255);
    s_ack = 1'b1;
    #1 chk("a255_ack", 64'(d_m_ack), 64'b0010);
    tick(); s_ack = 1'b0;
    chk("a255_noerr", 64'(d_m_err), 64'd0);
    chk("a255_held", 64'(d_grant), 64'b0010);
    tick();
    chk("a255_noerr2", 64'(d_m_err), 64'd0);
    quiesce();

    // Reset mid-burst clears everything at once; master 0 wins afterwards
    m_cyc = 4'b0100; m_stb = 4'b0100; m_we = 4'b0100; m_sel = '1;
    m_adr = {4{32'h0000_0A50}}; m_dat = {4{32'h1234_5678}};
    tick();
    chk("mr_grant", 64'(d_grant), 64'b0100);
    s_ack = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("mr_grant0", 64'(d_grant), 64'd0);
    chk("mr_busy0",  64'(d_busy),  64'd0);
    chk("mr_cyc0",   64'(d_s_cyc), 64'd0);
    chk("mr_stb0",   64'(d_s_stb), 64'd0);
    chk("mr_we0",    64'(d_s_we),  64'd0);
    chk("mr_adr0",   64'(d_s_adr), 64'd0);
    chk("mr_dat0",   64'(d_s_dat), 64'd0);
    chk("mr_sel0",   64'(d_s_sel), 64'd0);
    chk("mr_ack0",   64'(d_m_ack), 64'd0);
    chk("mr_err0",   64'(d_m_err), 64'd0);
    s_ack = 1'b0; m_cyc = 4'hF; m_stb = 4'hF;
    repeat (2) tick();
    chk("mr_hold", 64'(d_grant), 64'd0);
    rst = 1'b0;
    tick();
    chk("mr_first", 64'(d_grant), 64'b0001);
    quiesce();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
